// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle control unit: state encoding,
// ALU operation codes, and opcode/funct values decoded from the IR.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11,
      S_JUMP   = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_LUI  = 4'b1101;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // All eight opcodes 001000..001111 are immediate ALU instructions.
   function automatic logic is_itype(input logic [5:0] op);
      return op[5:3] == 3'b001;
   endfunction

endpackage

// File: rtl/mc_alu_ctrl.sv
// Combinational ALU-control decoder: R-type funct or I-type opcode to ALU code,
// immediate zero-extension select, and R-type funct legality.
module mc_alu_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [3:0] alu_code,
   output logic       imm_zext,
   output logic       funct_legal
);

   always_comb begin
      alu_code    = ALU_ADD;
      imm_zext    = 1'b0;
      funct_legal = 1'b0;
      if (op == OP_RTYPE) begin
         funct_legal = 1'b1;
         case (funct)
            FN_ADD, FN_ADDU: alu_code = ALU_ADD;
            FN_SUB, FN_SUBU: alu_code = ALU_SUB;
            FN_AND:          alu_code = ALU_AND;
            FN_OR:           alu_code = ALU_OR;
            FN_XOR:          alu_code = ALU_XOR;
            FN_NOR:          alu_code = ALU_NOR;
            FN_SLT:          alu_code = ALU_SLT;
            FN_SLTU:         alu_code = ALU_SLTU;
            default:         funct_legal = 1'b0;
         endcase
      end else begin
         case (op)
            OP_ADDI, OP_ADDIU: alu_code = ALU_ADD;
            OP_SLTI:           alu_code = ALU_SLT;
            OP_SLTIU:          alu_code = ALU_SLTU;
            OP_ANDI: begin alu_code = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:  begin alu_code = ALU_OR;  imm_zext = 1'b1; end
            OP_XORI: begin alu_code = ALU_XOR; imm_zext = 1'b1; end
            OP_LUI:            alu_code = ALU_LUI;
            default:           alu_code = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control unit: state machine driving datapath controls,
// sticky illegal-instruction trap and retired-instruction counter.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 4,
   parameter int MEM_WAIT_EN = 1,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               iord,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic               imm_zext,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         pc_src,
   output logic [ALUOP_W-1:0] alu_ctrl,
   output logic [3:0]         state,
   output logic               illegal_op,
   output logic               instr_done,
   output logic [CNT_W-1:0]   instr_count
);

   state_t           state_reg, state_next;
   logic             illegal_reg;
   logic [CNT_W-1:0] count_reg;
   logic [3:0]       alu_sel;
   logic [3:0]       dec_alu_code;
   logic             dec_imm_zext;
   logic             dec_funct_legal;
   logic             mem_ok;

   assign mem_ok = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   mc_alu_ctrl u_alu_ctrl (
      .op          (op),
      .funct       (funct),
      .alu_code    (dec_alu_code),
      .imm_zext    (dec_imm_zext),
      .funct_legal (dec_funct_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         illegal_reg <= 1'b0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         illegal_reg <= illegal_reg | (state_next == S_TRAP);
         if (instr_done)
            count_reg <= count_reg + CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      imm_zext   = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_sel    = ALU_AND;
      instr_done = 1'b0;
      case (state_reg)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_sel   = ALU_ADD;
            ir_write  = mem_ok;
            pc_write  = mem_ok;
            if (mem_ok) state_next = S_DECODE;
         end
         S_DECODE: begin
            // Speculatively compute the branch target while the opcode is decoded.
            alu_src_b = 2'b11;
            alu_sel   = ALU_ADD;
            case (op)
               OP_LW, OP_SW:   state_next = S_MEMADR;
               OP_RTYPE:       state_next = dec_funct_legal ? S_EXEC : S_TRAP;
               OP_BEQ, OP_BNE: state_next = S_BRANCH;
               OP_J:           state_next = S_JUMP;
               default:        state_next = is_itype(op) ? S_IEXEC : S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_sel    = ALU_ADD;
            state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ok) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ok;
            if (mem_ok) state_next = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a  = 1'b1;
            alu_sel    = dec_alu_code;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_sel    = ALU_SUB;
            pc_src     = 2'b01;
            pc_write   = (op == OP_BNE) ? ~zero : zero;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_IEXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_sel    = dec_alu_code;
            imm_zext   = dec_imm_zext;
            state_next = S_IWB;
         end
         S_IWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_TRAP;
      endcase
   end

   assign alu_ctrl    = ALUOP_W'(alu_sel);
   assign state       = state_reg;
   assign illegal_op  = illegal_reg;
   assign instr_count = count_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a per-cycle vector table for a program of
// mixed instructions, plus hand sequences for resets, traps and a narrow counter.
module tb_mc_control_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, rst2_n;
   logic [5:0]  op, funct, op2;
   logic        zero, mem_ready, mem_ready2;

   logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst;
   logic        mem_to_reg, alu_src_a, imm_zext, illegal_op, instr_done;
   logic [1:0]  alu_src_b, pc_src;
   logic [3:0]  alu_ctrl, state;
   logic [15:0] instr_count;
   logic [13:0] ctl;

   logic        pc_write2, ir_write2, mem_read2, mem_write2, iord2, reg_write2, reg_dst2;
   logic        mem_to_reg2, alu_src_a2, imm_zext2, illegal_op2, instr_done2;
   logic [1:0]  alu_src_b2, pc_src2;
   logic [3:0]  alu_ctrl2, state2;
   logic [1:0]  instr_count2;

   assign ctl = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
                 mem_to_reg, alu_src_a, imm_zext, alu_src_b, pc_src};

   mc_control_fsm #(.ALUOP_W(4), .MEM_WAIT_EN(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .imm_zext(imm_zext), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_ctrl(alu_ctrl), .state(state), .illegal_op(illegal_op), .instr_done(instr_done),
      .instr_count(instr_count)
   );

   mc_control_fsm #(.ALUOP_W(4), .MEM_WAIT_EN(0), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .op(op2), .funct(funct), .zero(zero), .mem_ready(mem_ready2),
      .pc_write(pc_write2), .ir_write(ir_write2), .mem_read(mem_read2), .mem_write(mem_write2),
      .iord(iord2), .reg_write(reg_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
      .alu_src_a(alu_src_a2), .imm_zext(imm_zext2), .alu_src_b(alu_src_b2), .pc_src(pc_src2),
      .alu_ctrl(alu_ctrl2), .state(state2), .illegal_op(illegal_op2), .instr_done(instr_done2),
      .instr_count(instr_count2)
   );

   // Control word order: pcw irw mrd mwr iord rw rdst m2r asa zext asb[1:0] pcsrc[1:0]
   localparam logic [13:0] C_NONE = 14'b00000000000000;
   localparam logic [13:0] C_F    = 14'b11100000000100;
   localparam logic [13:0] C_FW   = 14'b00100000000100;
   localparam logic [13:0] C_D    = 14'b00000000001100;
   localparam logic [13:0] C_MA   = 14'b00000000101000;
   localparam logic [13:0] C_MR   = 14'b00101000000000;
   localparam logic [13:0] C_MWB  = 14'b00000101000000;
   localparam logic [13:0] C_MW   = 14'b00011000000000;
   localparam logic [13:0] C_EX   = 14'b00000000100000;
   localparam logic [13:0] C_AWB  = 14'b00000110000000;
   localparam logic [13:0] C_BRT  = 14'b10000000100001;
   localparam logic [13:0] C_BRN  = 14'b00000000100001;
   localparam logic [13:0] C_IE   = 14'b00000000101000;
   localparam logic [13:0] C_IEZ  = 14'b00000000111000;
   localparam logic [13:0] C_IWB  = 14'b00000100000000;
   localparam logic [13:0] C_J    = 14'b10000000000010;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
   localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ANDI = 6'b001100;
   localparam logic [5:0] LUI = 6'b001111, SLTI = 6'b001010;
   localparam logic [5:0] F_XOR = 6'b100110, F_NOR = 6'b100111, F_BAD = 6'b000111;

   // Narrow-counter instance: lw then three jumps with mem_ready held low.
   localparam logic [3:0] EXP2_ST  [16] = '{0, 1, 2, 3, 4, 5, 1, 2, 12, 1, 2, 12, 1, 2, 12, 1};
   localparam logic [1:0] EXP2_CNT [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        mr;
      logic [3:0]  st;
      logic [13:0] ctl;
      logic [3:0]  alu;
      logic        done;
      logic [15:0] cnt;
      logic        ill;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input logic mr,
                      input logic [3:0] st, input logic [13:0] c, input logic [3:0] alu,
                      input logic done, input logic [15:0] cnt, input logic ill);
      vec_t v;
      v.op = o; v.fn = f; v.z = z; v.mr = mr; v.st = st; v.ctl = c;
      v.alu = alu; v.done = done; v.cnt = cnt; v.ill = ill;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      op = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      op2 = LW; mem_ready2 = 1'b0;

      add(LW, 0, 0, 1,  0, C_NONE, 0, 0, 0, 0);
      add(LW, 0, 0, 1,  1, C_F,    2, 0, 0, 0);
      add(LW, 0, 0, 1,  2, C_D,    2, 0, 0, 0);
      add(LW, 0, 0, 1,  3, C_MA,   2, 0, 0, 0);
      add(LW, 0, 0, 1,  4, C_MR,   0, 0, 0, 0);
      add(LW, 0, 0, 1,  5, C_MWB,  0, 1, 0, 0);
      add(SW, 0, 0, 1,  1, C_F,    2, 0, 1, 0);
      add(SW, 0, 0, 1,  2, C_D,    2, 0, 1, 0);
      add(SW, 0, 0, 1,  3, C_MA,   2, 0, 1, 0);
      add(SW, 0, 0, 0,  6, C_MW,   0, 0, 1, 0);
      add(SW, 0, 0, 0,  6, C_MW,   0, 0, 1, 0);
      add(SW, 0, 0, 0,  6, C_MW,   0, 0, 1, 0);
      add(SW, 0, 0, 1,  6, C_MW,   0, 1, 1, 0);
      add(RT, F_XOR, 0, 0, 1, C_FW,  2, 0, 2, 0);
      add(RT, F_XOR, 0, 1, 1, C_F,   2, 0, 2, 0);
      add(RT, F_XOR, 0, 1, 2, C_D,   2, 0, 2, 0);
      add(RT, F_XOR, 0, 1, 7, C_EX,  3, 0, 2, 0);
      add(RT, F_XOR, 0, 1, 8, C_AWB, 0, 1, 2, 0);
      add(BEQ, 0, 1, 1, 1, C_F,   2, 0, 3, 0);
      add(BEQ, 0, 1, 1, 2, C_D,   2, 0, 3, 0);
      add(BEQ, 0, 1, 1, 9, C_BRT, 6, 1, 3, 0);
      add(BNE, 0, 1, 1, 1, C_F,   2, 0, 4, 0);
      add(BNE, 0, 1, 1, 2, C_D,   2, 0, 4, 0);
      add(BNE, 0, 1, 1, 9, C_BRN, 6, 1, 4, 0);
      add(BNE, 0, 0, 1, 1, C_F,   2, 0, 5, 0);
      add(BNE, 0, 0, 1, 2, C_D,   2, 0, 5, 0);
      add(BNE, 0, 0, 1, 9, C_BRT, 6, 1, 5, 0);
      add(ANDI, 0, 0, 1,  1, C_F,   2, 0, 6, 0);
      add(ANDI, 0, 0, 1,  2, C_D,   2, 0, 6, 0);
      add(ANDI, 0, 0, 1, 10, C_IEZ, 0, 0, 6, 0);
      add(ANDI, 0, 0, 1, 11, C_IWB, 0, 1, 6, 0);
      add(LUI, 0, 0, 1,  1, C_F,   2,  0, 7, 0);
      add(LUI, 0, 0, 1,  2, C_D,   2,  0, 7, 0);
      add(LUI, 0, 0, 1, 10, C_IE,  13, 0, 7, 0);
      add(LUI, 0, 0, 1, 11, C_IWB, 0,  1, 7, 0);
      add(SLTI, 0, 0, 1,  1, C_F,   2, 0, 8, 0);
      add(SLTI, 0, 0, 1,  2, C_D,   2, 0, 8, 0);
      add(SLTI, 0, 0, 1, 10, C_IE,  7, 0, 8, 0);
      add(SLTI, 0, 0, 1, 11, C_IWB, 0, 1, 8, 0);
      add(RT, F_NOR, 0, 1, 1, C_F,   2,  0, 9, 0);
      add(RT, F_NOR, 0, 1, 2, C_D,   2,  0, 9, 0);
      add(RT, F_NOR, 0, 1, 7, C_EX,  12, 0, 9, 0);
      add(RT, F_NOR, 0, 1, 8, C_AWB, 0,  1, 9, 0);
      add(JMP, 0, 0, 1,  1, C_F, 2, 0, 10, 0);
      add(JMP, 0, 0, 1,  2, C_D, 2, 0, 10, 0);
      add(JMP, 0, 0, 1, 12, C_J, 0, 1, 10, 0);
      add(RT, F_BAD, 0, 1,  1, C_F,    2, 0, 11, 0);
      add(RT, F_BAD, 0, 1,  2, C_D,    2, 0, 11, 0);
      add(RT, F_BAD, 0, 1, 13, C_NONE, 0, 0, 11, 1);
      add(RT, F_BAD, 0, 1, 13, C_NONE, 0, 0, 11, 1);
      add(RT, F_BAD, 0, 1, 13, C_NONE, 0, 0, 11, 1);

      // Reset held: outputs must already be quiescent.
      @(negedge clk);
      #1;
      chk("reset_state", state, 0);
      chk("reset_ctl", ctl, 0);
      chk("reset_count", instr_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         op = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; mem_ready = vecs[i].mr;
         #1;
         chk($sformatf("v%0d_state", i), state,       vecs[i].st);
         chk($sformatf("v%0d_ctl", i),   ctl,         vecs[i].ctl);
         chk($sformatf("v%0d_alu", i),   alu_ctrl,    vecs[i].alu);
         chk($sformatf("v%0d_done", i),  instr_done,  vecs[i].done);
         chk($sformatf("v%0d_count", i), instr_count, vecs[i].cnt);
         chk($sformatf("v%0d_ill", i),   illegal_op,  vecs[i].ill);
         $display("vec %0d: op=%b state=%0d done=%0d count=%0d", i, op, state, instr_done, instr_count);
         @(negedge clk);
      end

      // Asynchronous reset out of TRAP, mid-cycle.
      #2 rst_n = 1'b0;
      #1;
      chk("trap_rst_state", state, 0);
      chk("trap_rst_ill", illegal_op, 0);
      chk("trap_rst_count", instr_count, 0);
      $display("seq trap reset: state=%0d ill=%0d", state, illegal_op);
      @(negedge clk);
      rst_n = 1'b1;
      op = LW; mem_ready = 1'b1;
      #1 chk("rel_idle", state, 0);
      @(negedge clk); #1 chk("rel_fetch", state, 1);
      @(negedge clk); #1 chk("lw_decode", state, 2);
      @(negedge clk); #1 chk("lw_memadr", state, 3);
      @(negedge clk);
      mem_ready = 1'b0;
      #1 chk("wait1_state", state, 4);
      chk("wait1_done", instr_done, 0);
      @(negedge clk);
      #1 chk("wait2_state", state, 4);
      chk("wait2_mem_read", mem_read, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_state", state, 0);
      chk("abort_done", instr_done, 0);
      chk("abort_count", instr_count, 0);
      chk("abort_mem_read", mem_read, 0);
      $display("seq abort lw: state=%0d count=%0d", state, instr_count);
      @(negedge clk);
      rst_n = 1'b1;
      op = 6'b111111; mem_ready = 1'b1;
      #1 chk("rel2_idle", state, 0);
      @(negedge clk); #1 chk("rel2_fetch", state, 1);
      @(negedge clk); #1 chk("badop_decode", state, 2);
      chk("badop_ill_pre", illegal_op, 0);
      @(negedge clk); #1 chk("badop_trap", state, 13);
      chk("badop_ill", illegal_op, 1);
      $display("seq bad opcode: state=%0d ill=%0d", state, illegal_op);
      rst_n = 1'b0;

      // Narrow counter with memory waits disabled (mem_ready2 held 0).
      @(negedge clk);
      rst2_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         op2 = (k < 6) ? LW : JMP;
         #1;
         chk($sformatf("n%0d_state", k), state2, EXP2_ST[k]);
         chk($sformatf("n%0d_count", k), instr_count2, EXP2_CNT[k]);
         $display("narrow %0d: state=%0d count=%0d", k, state2, instr_count2);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4, width of alu_ctrl (must be >= 4; codes zero-extended).
REQ-002 SHALL have parameter MEM_WAIT_EN, default 1. 1 = honour mem_ready; 0 = memory single-cycle, mem_ready ignored (treated as 1).
REQ-003 SHALL have parameter CNT_W, default 16, width of instr_count.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 op  in  6  opcode from instruction register; funct  in  6  R-type function field.
REQ-007 zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete this cycle.
REQ-008 pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a, imm_zext  out  1 each  datapath controls.
REQ-009 alu_src_b  out  2  (00 reg B, 01 const 4, 10 immediate, 11 imm<<2); pc_src  out  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-010 alu_ctrl  out  ALUOP_W  ALU operation.
REQ-011 state  out  4  current state; illegal_op  out  1  sticky trap flag; instr_done  out  1  retire pulse; instr_count  out  CNT_W  retired-instruction count.

Function
REQ-012 States (4-bit): IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, IEXEC=10, IWB=11, JUMP=12, TRAP=13. Codes 14-15 go to TRAP.
REQ-013 ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, NOR 1100, LUI 1101.
REQ-014 Outputs combinational from state (plus op, funct, zero, mem_ready where stated); any control not listed for a state is 0.
REQ-015 IDLE: all controls 0; next FETCH.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00. ir_write=pc_write=mem_ready. Stay while mem_ready=0; else DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD. Next by op: 100011/101011 -> MEMADR; 000000 -> EXEC if funct legal, else TRAP; 000100/000101 -> BRANCH; 000010 -> JUMP; 001000-001111 -> IEXEC; any other op -> TRAP.
REQ-018 Legal funct: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD; next MEMRD for lw, MEMWR for sw.
REQ-020 MEMRD: mem_read=1, iord=1; stay while mem_ready=0; else MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-021 MEMWR: mem_write=1, iord=1; stay while mem_ready=0; else FETCH. mem_write held high during wait.
REQ-022 EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct; next ALUWB. ALUWB: reg_write=1, reg_dst=1; next FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01, pc_write = zero for beq, ~zero for bne; next FETCH.
REQ-024 IEXEC: alu_src_a=1, alu_src_b=10; alu_ctrl: addi/addiu ADD, slti SLT, sltiu SLTU, andi AND, ori OR, xori XOR, lui LUI; imm_zext=1 for andi/ori/xori. Next IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-025 JUMP: pc_src=10, pc_write=1; next FETCH.
REQ-026 TRAP: all controls 0, illegal_op=1; stays in TRAP until reset.
REQ-027 instr_done=1 for exactly one cycle in the final state of each instruction (MEMWB, MEMWR with mem_ready, ALUWB, BRANCH, IWB, JUMP); instr_count increments on that edge, wraps modulo 2^CNT_W.
REQ-028 Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, I-type ALU 4, branch 3, jump 3.
REQ-029 With MEM_WAIT_EN=0, FETCH/MEMRD/MEMWR always last exactly one cycle.

Reset
REQ-030 rst_n low asynchronously forces state=IDLE, illegal_op=0, instr_count=0; all controls 0, instr_done=0.
REQ-031 Reset asserted mid-instruction or mid-wait aborts it without retire; after release, FETCH follows one IDLE cycle.

Structure
REQ-032 State codes, ALU codes, opcode and funct constants SHALL live in a shared package (mc_ctrl_pkg).
REQ-033 One sub-module, mc_alu_ctrl (combinational op/funct -> alu_ctrl, imm_zext, funct_legal); the FSM and counter are in the top module.

Verification
REQ-034 Release reset, mem_ready=1, op=100011 -> states 0,1,2,3,4,5,1; reg_write and mem_to_reg high in MEMWB; instr_count=1.
REQ-035 sw with mem_ready low 3 cycles in MEMWR -> mem_write high 4 cycles, single instr_done, then FETCH.
REQ-036 beq, zero=1 -> pc_write=1 in BRANCH; bne, zero=1 -> pc_write=0; both retire.
REQ-037 R-type funct=100110 -> alu_ctrl=0011 in EXEC; funct=000111 -> TRAP, illegal_op=1, held until rst_n low.
REQ-038 CNT_W=2, four retired instructions -> instr_count 1,2,3,0.
REQ-039 rst_n low during MEMRD wait -> immediate IDLE, instr_count unchanged, no instr_done.
